// File: rtl/hub75_scan_scheduler.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : hub75_scan_scheduler
// Brief    : HUB75 refresh sequencer - shift request, blank, latch, BCM on-time
// Revision : 1.0 - initial release
// ============================================================================
module hub75_scan_scheduler #(
    parameter int SCAN_RATE    = 32,
    parameter int PLANES       = 3,
    parameter int BASE_ON      = 16,
    parameter int BLANK_CYCLES = 2,
    parameter int LATCH_CYCLES = 2
) (
    input  logic                         clk_in,
    input  logic                         rst_in,
    input  logic                         enable_in,
    input  logic                         frame_start_in,
    output logic                         shift_req_out,
    output logic [$clog2(SCAN_RATE)-1:0] row_out,
    output logic [$clog2(PLANES)-1:0]    plane_out,
    input  logic                         shift_done_in,
    output logic [$clog2(SCAN_RATE)-1:0] addr_out,
    output logic                         latch_out,
    output logic                         oe_n_out,
    output logic                         frame_done_out
);
    localparam int RW   = $clog2(SCAN_RATE);
    localparam int PW   = $clog2(PLANES);
    localparam int TW   = $clog2(BASE_ON << (PLANES - 1)) + 1;
    localparam int CMAX = (BLANK_CYCLES > LATCH_CYCLES) ? BLANK_CYCLES : LATCH_CYCLES;
    localparam int CW   = (CMAX > 1) ? $clog2(CMAX) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        BLANK = 2'd2,
        LATCH = 2'd3
    } state_t;

    state_t          state, state_nxt;
    logic [CW-1:0]   cnt, cnt_nxt;
    logic [TW-1:0]   timer, timer_nxt;
    logic            done_flag, done_nxt;
    logic            restart_flag, restart_nxt;
    logic [PW-1:0]   disp_plane, disp_nxt;
    logic [RW-1:0]   row_nxt, addr_nxt;
    logic [PW-1:0]   plane_nxt;
    logic            shift_req_nxt, latch_nxt, oe_n_nxt, frame_done_nxt;
    logic            restart_now, last_row, last_plane;

    assign restart_now = restart_flag | frame_start_in;
    assign last_row    = (row_out == RW'(SCAN_RATE - 1));
    assign last_plane  = (plane_out == PW'(PLANES - 1));

    always_comb begin
        state_nxt      = state;
        cnt_nxt        = cnt;
        timer_nxt      = (timer != '0) ? timer - TW'(1) : timer;
        done_nxt       = done_flag;
        restart_nxt    = restart_now;
        row_nxt        = row_out;
        plane_nxt      = plane_out;
        addr_nxt       = addr_out;
        disp_nxt       = disp_plane;
        frame_done_nxt = 1'b0;

        case (state)
            IDLE: begin
                if (frame_start_in) begin
                    row_nxt     = '0;
                    plane_nxt   = '0;
                    restart_nxt = 1'b0;
                end
                if (enable_in) begin
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                if (shift_done_in) begin
                    done_nxt = 1'b1;
                end
                // Wait for both the shifter and the previous plane's on-time.
                if ((done_flag || shift_done_in) && (timer == '0)) begin
                    state_nxt = BLANK;
                    cnt_nxt   = '0;
                end
            end
            BLANK: begin
                if (cnt == CW'(BLANK_CYCLES - 1)) begin
                    state_nxt = LATCH;
                    cnt_nxt   = '0;
                    addr_nxt  = row_out;
                    disp_nxt  = plane_out;
                end else begin
                    cnt_nxt = cnt + CW'(1);
                end
            end
            LATCH: begin
                if (cnt == CW'(LATCH_CYCLES - 1)) begin
                    cnt_nxt        = '0;
                    timer_nxt      = TW'(BASE_ON << disp_plane);
                    done_nxt       = 1'b0;
                    restart_nxt    = 1'b0;
                    frame_done_nxt = last_row && last_plane && !restart_now;
                    if (restart_now) begin
                        row_nxt   = '0;
                        plane_nxt = '0;
                    end else if (last_plane) begin
                        plane_nxt = '0;
                        row_nxt   = last_row ? '0 : row_out + RW'(1);
                    end else begin
                        plane_nxt = plane_out + PW'(1);
                    end
                    state_nxt = enable_in ? SHIFT : IDLE;
                end else begin
                    cnt_nxt = cnt + CW'(1);
                end
            end
            default: state_nxt = IDLE;
        endcase

        // Outputs are registered copies of what the next state implies.
        shift_req_nxt = (state_nxt == SHIFT) && !done_nxt;
        latch_nxt     = (state_nxt == LATCH);
        oe_n_nxt      = !((timer_nxt != '0) && (state_nxt != BLANK) && (state_nxt != LATCH));
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state          <= IDLE;
            cnt            <= '0;
            timer          <= '0;
            done_flag      <= 1'b0;
            restart_flag   <= 1'b0;
            disp_plane     <= '0;
            row_out        <= '0;
            plane_out      <= '0;
            addr_out       <= '0;
            shift_req_out  <= 1'b0;
            latch_out      <= 1'b0;
            oe_n_out       <= 1'b1;
            frame_done_out <= 1'b0;
        end else begin
            state          <= state_nxt;
            cnt            <= cnt_nxt;
            timer          <= timer_nxt;
            done_flag      <= done_nxt;
            restart_flag   <= restart_nxt;
            disp_plane     <= disp_nxt;
            row_out        <= row_nxt;
            plane_out      <= plane_nxt;
            addr_out       <= addr_nxt;
            shift_req_out  <= shift_req_nxt;
            latch_out      <= latch_nxt;
            oe_n_out       <= oe_n_nxt;
            frame_done_out <= frame_done_nxt;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_hub75_scan_scheduler.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_hub75_scan_scheduler
// Brief    : Randomised bench for hub75_scan_scheduler against an event-timeline model
// Revision : 1.0 - initial release
// ============================================================================
module tb_hub75_scan_scheduler;
    localparam int SR   = 4;
    localparam int PL   = 3;
    localparam int BO   = 4;
    localparam int BC   = 2;
    localparam int LC   = 2;
    localparam int NP   = SR * PL;
    localparam int NMAX = 2048;

    logic       clk = 1'b0;
    logic       rst_in = 1'b0;
    logic       enable_in = 1'b0;
    logic       frame_start_in = 1'b0;
    logic       shift_done_in = 1'b0;
    logic       shift_req_out, latch_out, oe_n_out, frame_done_out;
    logic [1:0] row_out, plane_out, addr_out;

    int tests = 0;
    int fails = 0;
    int hz;
    int last_l;
    int dly [64];

    logic       e_req   [NMAX];
    logic [1:0] e_row   [NMAX];
    logic [1:0] e_plane [NMAX];
    logic [1:0] e_addr  [NMAX];
    logic       e_latch [NMAX];
    logic       e_oe_n  [NMAX];
    logic       e_fd    [NMAX];
    logic       i_done  [NMAX];
    logic       i_fs    [NMAX];
    logic       i_en    [NMAX];

    hub75_scan_scheduler #(
        .SCAN_RATE(SR), .PLANES(PL), .BASE_ON(BO), .BLANK_CYCLES(BC), .LATCH_CYCLES(LC)
    ) dut (
        .clk_in(clk), .rst_in(rst_in), .enable_in(enable_in), .frame_start_in(frame_start_in),
        .shift_req_out(shift_req_out), .row_out(row_out), .plane_out(plane_out),
        .shift_done_in(shift_done_in), .addr_out(addr_out), .latch_out(latch_out),
        .oe_n_out(oe_n_out), .frame_done_out(frame_done_out)
    );

    always #5 clk = ~clk;

    function automatic logic [9:0] pack(input logic req, input logic [1:0] row,
                                        input logic [1:0] plane, input logic [1:0] addr,
                                        input logic latch, input logic oe_n, input logic fd);
        return {req, req ? row : 2'b00, req ? plane : 2'b00, addr, latch, oe_n, fd};
    endfunction

    // Timeline per pair: request R, shifter answer D=R+dly, departure X=max(D, first
    // timer-zero cycle), latch X+BC+1..X+BC+LC, on-time the BO<<p cycles after it.
    task automatic build_model(input int npairs, input int rs_pair, input bit stop);
        int t, z, d, x, l, w, idx, r, p;
        for (int n = 0; n < NMAX; n++) begin
            e_req[n] = 0; e_row[n] = 0; e_plane[n] = 0; e_addr[n] = 0;
            e_latch[n] = 0; e_oe_n[n] = 1; e_fd[n] = 0;
            i_done[n] = 0; i_fs[n] = 0; i_en[n] = 1;
        end
        t = 1; z = 0; idx = 0; l = 0;
        for (int k = 0; k < npairs; k++) begin
            r = idx / PL;
            p = idx % PL;
            d = t + dly[k];
            x = (d > z) ? d : z;
            for (int n = t; n <= d; n++) begin
                e_req[n] = 1; e_row[n] = 2'(r); e_plane[n] = 2'(p);
            end
            i_done[d] = 1;
            if (k == rs_pair) i_fs[t + 1] = 1;
            l = x + BC + LC;
            for (int n = x + BC + 1; n <= l; n++) e_latch[n] = 1;
            for (int n = x + BC + 1; n < NMAX; n++) e_addr[n] = 2'(r);
            w = BO << p;
            for (int n = l + 1; n <= l + w; n++) e_oe_n[n] = 0;
            if (idx == NP - 1 && k != rs_pair) e_fd[l + 1] = 1;
            idx = (k == rs_pair) ? 0 : (idx + 1) % NP;
            z = l + w + 1;
            t = l + 1;
            hz = l + w + 4;
        end
        last_l = l;
        if (stop) begin
            for (int n = t - 1; n < NMAX; n++) i_en[n] = 0;
        end else begin
            for (int n = t; n < hz; n++) begin
                e_req[n] = 1; e_row[n] = 2'(idx / PL); e_plane[n] = 2'(idx % PL);
            end
        end
    endtask

    task automatic drive(input int n);
        enable_in = i_en[n];
        shift_done_in = i_done[n];
        frame_start_in = i_fs[n];
    endtask

    task automatic reset_dut();
        enable_in = 0; shift_done_in = 0; frame_start_in = 0;
        @(negedge clk);
        rst_in = 0;
        repeat (2) @(negedge clk);
        rst_in = 1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset();
        enable_in = 0; shift_done_in = 0; frame_start_in = 0; rst_in = 0;
        repeat (3) @(negedge clk);
        tests++;
        if ({shift_req_out, latch_out, oe_n_out, addr_out, frame_done_out} !== 6'b001000) begin
            fails++;
            $display("FAIL reset_hold: got req/latch/oe_n/addr/fd=%b required 001000",
                     {shift_req_out, latch_out, oe_n_out, addr_out, frame_done_out});
        end
        rst_in = 1;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            tests++;
            if (pack(shift_req_out, row_out, plane_out, addr_out, latch_out, oe_n_out, frame_done_out)
                !== pack(1'b0, 2'd0, 2'd0, 2'd0, 1'b0, 1'b1, 1'b0)) begin
                fails++;
                $display("FAIL reset_idle cycle %0d: got %b required idle outputs", n,
                    pack(shift_req_out, row_out, plane_out, addr_out, latch_out, oe_n_out, frame_done_out));
            end
            shift_done_in = (n == 5);
            frame_start_in = (n == 9);
        end
        shift_done_in = 0; frame_start_in = 0;
    endtask

    task automatic test_single_pair();
        logic [9:0] obs, expv;
        logic [3:0] q_req[$];
        int latch_cnt = 0, low_cnt = 0;
        logic prev_req = 0;
        reset_dut();
        dly[0] = 3;
        build_model(1, -1, 0);
        i_done[0] = 1;  // stray pulse while idle must be ignored
        for (int n = 0; n < hz; n++) begin
            @(negedge clk);
            obs = pack(shift_req_out, row_out, plane_out, addr_out, latch_out, oe_n_out, frame_done_out);
            expv = pack(e_req[n], e_row[n], e_plane[n], e_addr[n], e_latch[n], e_oe_n[n], e_fd[n]);
            tests++;
            if (obs !== expv) begin
                fails++;
                $display("FAIL single_pair cycle %0d: got %b required %b", n, obs, expv);
            end
            if (shift_req_out && !prev_req) q_req.push_back({row_out, plane_out});
            prev_req = shift_req_out;
            if (latch_out) latch_cnt++;
            if (!oe_n_out) low_cnt++;
            drive(n);
        end
        tests++;
        if (latch_cnt != LC || low_cnt != BO) begin
            fails++;
            $display("FAIL single_windows: got latch=%0d oe_low=%0d required latch=%0d oe_low=%0d",
                     latch_cnt, low_cnt, LC, BO);
        end
        tests++;
        if (q_req.size() < 2 || q_req[1] !== 4'b0001) begin
            fails++;
            $display("FAIL single_next_req: got %0d requests, second=%b required (0,1)",
                     q_req.size(), (q_req.size() > 1) ? q_req[1] : 4'hx);
        end
    endtask

    task automatic test_bcm_weights();
        logic [9:0] obs, expv;
        int q_win[$];
        logic [1:0] q_addr[$];
        int run = 0;
        logic prev_latch = 0;
        reset_dut();
        for (int k = 0; k < 4; k++) dly[k] = $urandom_range(6, 1);
        build_model(4, -1, 0);
        for (int n = 0; n < hz; n++) begin
            @(negedge clk);
            obs = pack(shift_req_out, row_out, plane_out, addr_out, latch_out, oe_n_out, frame_done_out);
            expv = pack(e_req[n], e_row[n], e_plane[n], e_addr[n], e_latch[n], e_oe_n[n], e_fd[n]);
            tests++;
            if (obs !== expv) begin
                fails++;
                $display("FAIL bcm cycle %0d: got %b required %b", n, obs, expv);
            end
            if (!oe_n_out) run++;
            else if (run > 0) begin q_win.push_back(run); run = 0; end
            if (latch_out && !prev_latch) q_addr.push_back(addr_out);
            prev_latch = latch_out;
            drive(n);
        end
        for (int k = 0; k < 4; k++) begin
            tests++;
            if (q_win.size() <= k || q_win[k] != (BO << (k % PL))) begin
                fails++;
                $display("FAIL bcm_window %0d: got %0d required %0d", k,
                         (q_win.size() > k) ? q_win[k] : -1, BO << (k % PL));
            end
            tests++;
            if (q_addr.size() <= k || q_addr[k] !== 2'(k / PL)) begin
                fails++;
                $display("FAIL bcm_addr %0d: got %0d required %0d", k,
                         (q_addr.size() > k) ? q_addr[k] : 2'bxx, k / PL);
            end
        end
    endtask

    // Shared by the overlap and stall scenarios: fixed shifter latency, checks the
    // blanked gap between the end of each on-time and the next latch pulse.
    task automatic test_overlap_stall(input int lat, input int npairs);
        logic [9:0] obs, expv;
        int hi = 0, k = 0, want;
        logic seen = 0, prev_latch = 0;
        reset_dut();
        for (int i = 0; i < npairs; i++) dly[i] = lat;
        build_model(npairs, -1, 0);
        for (int n = 0; n < hz; n++) begin
            @(negedge clk);
            obs = pack(shift_req_out, row_out, plane_out, addr_out, latch_out, oe_n_out, frame_done_out);
            expv = pack(e_req[n], e_row[n], e_plane[n], e_addr[n], e_latch[n], e_oe_n[n], e_fd[n]);
            tests++;
            if (obs !== expv) begin
                fails++;
                $display("FAIL overlap_lat%0d cycle %0d: got %b required %b", lat, n, obs, expv);
            end
            if (latch_out && !prev_latch) begin
                if (seen) begin
                    want = (lat + 1 > (BO << ((k - 1) % PL)) ? lat + 1 - (BO << ((k - 1) % PL)) : 1) + BC;
                    tests++;
                    if (hi != want) begin
                        fails++;
                        $display("FAIL gap_lat%0d pair %0d: got %0d blank cycles required %0d",
                                 lat, k, hi, want);
                    end
                end
                k++;
            end
            prev_latch = latch_out;
            if (!oe_n_out) begin seen = 1; hi = 0; end
            else hi++;
            drive(n);
        end
    endtask

    task automatic test_wrap();
        logic [9:0] obs, expv;
        logic [3:0] q_req[$];
        int fd_cnt = 0;
        logic prev_req = 0;
        reset_dut();
        for (int k = 0; k < NP; k++) dly[k] = $urandom_range(30, 1);
        build_model(NP, -1, 0);
        for (int n = 0; n < hz; n++) begin
            @(negedge clk);
            obs = pack(shift_req_out, row_out, plane_out, addr_out, latch_out, oe_n_out, frame_done_out);
            expv = pack(e_req[n], e_row[n], e_plane[n], e_addr[n], e_latch[n], e_oe_n[n], e_fd[n]);
            tests++;
            if (obs !== expv) begin
                fails++;
                $display("FAIL wrap cycle %0d: got %b required %b", n, obs, expv);
            end
            if (frame_done_out) fd_cnt++;
            if (shift_req_out && !prev_req) q_req.push_back({row_out, plane_out});
            prev_req = shift_req_out;
            drive(n);
        end
        tests++;
        if (fd_cnt != 1) begin
            fails++;
            $display("FAIL wrap_frame_done: got %0d pulses required 1", fd_cnt);
        end
        tests++;
        if (q_req.size() <= NP || q_req[NP] !== 4'b0000) begin
            fails++;
            $display("FAIL wrap_next_req: got %0d requests, last=%b required (0,0)",
                     q_req.size(), (q_req.size() > NP) ? q_req[NP] : 4'hx);
        end
    endtask

    task automatic test_restart();
        logic [9:0] obs, expv;
        logic [3:0] q_req[$];
        logic [1:0] q_addr[$];
        int fd_cnt = 0;
        logic prev_req = 0, prev_latch = 0;
        reset_dut();
        for (int k = 0; k < 9; k++) dly[k] = $urandom_range(10, 2);
        dly[7] = 5;
        build_model(9, 7, 0);
        for (int n = 0; n < hz; n++) begin
            @(negedge clk);
            obs = pack(shift_req_out, row_out, plane_out, addr_out, latch_out, oe_n_out, frame_done_out);
            expv = pack(e_req[n], e_row[n], e_plane[n], e_addr[n], e_latch[n], e_oe_n[n], e_fd[n]);
            tests++;
            if (obs !== expv) begin
                fails++;
                $display("FAIL restart cycle %0d: got %b required %b", n, obs, expv);
            end
            if (frame_done_out) fd_cnt++;
            if (shift_req_out && !prev_req) q_req.push_back({row_out, plane_out});
            if (latch_out && !prev_latch) q_addr.push_back(addr_out);
            prev_req = shift_req_out;
            prev_latch = latch_out;
            drive(n);
        end
        tests++;
        if (q_addr.size() < 8 || q_addr[7] !== 2'd2) begin
            fails++;
            $display("FAIL restart_latched_addr: got %0d required 2",
                     (q_addr.size() > 7) ? q_addr[7] : 2'bxx);
        end
        tests++;
        if (q_req.size() < 9 || q_req[8] !== 4'b0000) begin
            fails++;
            $display("FAIL restart_next_req: got %b required (0,0)",
                     (q_req.size() > 8) ? q_req[8] : 4'hx);
        end
        tests++;
        if (fd_cnt != 0) begin
            fails++;
            $display("FAIL restart_frame_done: got %0d pulses required 0", fd_cnt);
        end
    endtask

    task automatic test_idle_drain();
        logic [9:0] obs, expv;
        reset_dut();
        dly[0] = $urandom_range(8, 1);
        dly[1] = $urandom_range(8, 1);
        build_model(2, -1, 1);
        for (int n = 0; n < hz; n++) begin
            @(negedge clk);
            obs = pack(shift_req_out, row_out, plane_out, addr_out, latch_out, oe_n_out, frame_done_out);
            expv = pack(e_req[n], e_row[n], e_plane[n], e_addr[n], e_latch[n], e_oe_n[n], e_fd[n]);
            tests++;
            if (obs !== expv) begin
                fails++;
                $display("FAIL idle_drain cycle %0d: got %b required %b", n, obs, expv);
            end
            drive(n);
        end
    endtask

    task automatic test_back_to_back();
        logic [9:0] obs, expv;
        reset_dut();
        for (int k = 0; k < 20; k++) dly[k] = $urandom_range(40, 1);
        build_model(20, -1, 0);
        for (int n = 0; n < hz; n++) begin
            @(negedge clk);
            obs = pack(shift_req_out, row_out, plane_out, addr_out, latch_out, oe_n_out, frame_done_out);
            expv = pack(e_req[n], e_row[n], e_plane[n], e_addr[n], e_latch[n], e_oe_n[n], e_fd[n]);
            tests++;
            if (obs !== expv) begin
                fails++;
                $display("FAIL back_to_back cycle %0d: got %b required %b", n, obs, expv);
            end
            drive(n);
        end
    endtask

    task automatic test_async_reset();
        logic [9:0] obs, expv;
        reset_dut();
        for (int k = 0; k < 4; k++) dly[k] = $urandom_range(5, 1);
        build_model(4, -1, 0);
        for (int n = 0; n <= last_l + 2; n++) begin
            @(negedge clk);
            obs = pack(shift_req_out, row_out, plane_out, addr_out, latch_out, oe_n_out, frame_done_out);
            expv = pack(e_req[n], e_row[n], e_plane[n], e_addr[n], e_latch[n], e_oe_n[n], e_fd[n]);
            tests++;
            if (obs !== expv) begin
                fails++;
                $display("FAIL async_pre cycle %0d: got %b required %b", n, obs, expv);
            end
            drive(n);
        end
        #2 rst_in = 0;
        #1;
        tests++;
        if ({shift_req_out, latch_out, oe_n_out, addr_out, frame_done_out} !== 6'b001000) begin
            fails++;
            $display("FAIL async_reset: got req/latch/oe_n/addr/fd=%b required 001000",
                     {shift_req_out, latch_out, oe_n_out, addr_out, frame_done_out});
        end
        enable_in = 0; shift_done_in = 0; frame_start_in = 0;
        repeat (2) @(negedge clk);
        rst_in = 1;
    endtask

    initial begin
        test_reset();
        test_single_pair();
        test_bcm_weights();
        test_overlap_stall(1, 6);
        test_overlap_stall(30, 4);
        test_wrap();
        test_restart();
        test_idle_drain();
        test_back_to_back();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
`default_nettype wire

// File: doc/hub75_scan_scheduler.md
# hub75_scan_scheduler

Sequences the HUB75 panel refresh: steps through every (row, bit-plane) pair, requests the column shifter to clock out that row's plane data, then blanks, latches, drives the row address and holds the panel enabled for a binary-weighted on-time. Shifting of the next plane overlaps display of the current one. The block sits between `frame_manager` and `hub75_output` and owns the `hub75_addr`, latch and output-enable pins.

## Interface

Parameters:

- `SCAN_RATE`, default 32: rows per half-panel; row index width is `$clog2(SCAN_RATE)`.
- `PLANES`, default 3: BCM bit-planes per colour (RGB_RES/3).
- `BASE_ON`, default 16: on-time of plane 0, in clocks. Plane p lasts `BASE_ON<<p` clocks.
- `BLANK_CYCLES`, default 2: clocks with OE deasserted before the latch.
- `LATCH_CYCLES`, default 2: latch pulse width, in clocks.

Ports:

- `clk_in` in 1: system clock.
- `rst_in` in 1: asynchronous, active-low reset.
- `enable_in` in 1: run the refresh sequence.
- `frame_start_in` in 1: one-cycle pulse; restart the sequence at row 0, plane 0.
- `shift_req_out` out 1: request the shifter to load `row_out`/`plane_out`.
- `row_out` out `$clog2(SCAN_RATE)`: row being requested.
- `plane_out` out `$clog2(PLANES)`: plane being requested.
- `shift_done_in` in 1: one-cycle pulse from the shifter when the shift is complete.
- `addr_out` out `$clog2(SCAN_RATE)`: HUB75 row address of the latched row.
- `latch_out` out 1: HUB75 latch, active-high.
- `oe_n_out` out 1: HUB75 output enable, active-low (1 = blank).
- `frame_done_out` out 1: one-cycle pulse after the last row/plane is latched.

## Operation

- **Reset values:** state IDLE, `shift_req_out`=0, `row_out`=0, `plane_out`=0, `addr_out`=0, `latch_out`=0, `oe_n_out`=1, `frame_done_out`=0, on-timer=0, done flag=0, restart flag=0.
- **Visit order:** the plane index is inner and the row index is outer: (r0,p0), (r0,p1), …, (r0,pPLANES-1), (r1,p0), … After (SCAN_RATE-1, PLANES-1) the sequence wraps to (0,0).
- **IDLE:** outputs idle. If `enable_in`=1, go to SHIFT.
- **SHIFT:**
  - `shift_req_out`=1, with `row_out`/`plane_out` stable, until `shift_done_in` is seen. The pulse sets the done flag, and `shift_req_out` drops the next cycle.
  - Leave for BLANK when the done flag is set and the on-timer is 0. This may happen on the same cycle the pulse arrives if the timer is already 0.
  - If `shift_done_in` arrives while the state is not SHIFT, ignore it.
- **BLANK:** `oe_n_out`=1 for BLANK_CYCLES clocks, then go to LATCH.
- **LATCH:**
  - On entry, `addr_out` is set to `row_out`, and the displayed plane is captured.
  - `latch_out`=1 for LATCH_CYCLES clocks.
- **On LATCH exit:**
  - Load the on-timer with `BASE_ON<<displayed_plane` and clear the done flag.
  - Advance the (row, plane) pointer. If the restart flag is set, force the pointer to (0,0) and clear the flag.
  - `frame_done_out` pulses one cycle if the latched pair was (SCAN_RATE-1, PLANES-1) and no restart is pending.
  - If `enable_in`=1 go to SHIFT, otherwise go to IDLE. In IDLE the timer still counts down and OE stays enabled until it expires.
- **On-timer:**
  - Decrements by 1 every clock while nonzero, in every state.
  - `oe_n_out` = 0 iff timer≠0 and state is neither BLANK nor LATCH.
  - Timer width is `$clog2(BASE_ON<<(PLANES-1))+1`. Timer arithmetic never wraps.
- **`frame_start_in`:** sets the restart flag in any state. In IDLE it also sets the pointer to (0,0) immediately and clears the flag. A shift in flight is never aborted.
- **Mid-operation reset:** every register returns to its reset value immediately (asynchronous), so the panel is blanked at once.

## Timing

- Clock edge t = first cycle of IDLE with `enable_in`=1: `shift_req_out`=1 at t+1.
- `shift_done_in` at cycle d with the timer at 0:
  - BLANK occupies d+1 .. d+BLANK_CYCLES.
  - LATCH occupies the next LATCH_CYCLES cycles; `addr_out` is updated on the first LATCH cycle.
  - `oe_n_out`=0 starts the cycle after the last LATCH cycle and lasts exactly `BASE_ON<<p` cycles.
- `shift_req_out` for the next pair is asserted on the same cycle the display on-time starts.
- If the shift finishes before the timer expires, BLANK begins the cycle after the timer reaches 0, giving back-to-back refresh with no idle gap.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan

All scenarios use SCAN_RATE=4, PLANES=3, BASE_ON=4, BLANK_CYCLES=2, LATCH_CYCLES=2.

- **Reset:**
  - Stimulus: hold `rst_in`=0, then release with `enable_in`=0.
  - Required: `oe_n_out`=1, `latch_out`=0, `shift_req_out`=0, `addr_out`=0 indefinitely.
- **Single pair:**
  - Stimulus: `enable_in`=1; shifter answers `shift_done_in` 3 cycles after request.
  - Required: 2 blank cycles, then 2 latch cycles with `addr_out`=0, then `oe_n_out` low 4 cycles. The next request shows row 0, plane 1.
- **BCM weights:**
  - Stimulus: run one full row.
  - Required: OE-low windows of 4, 8, 16 cycles for planes 0, 1, 2; `addr_out` advances 0→1 only after plane 2.
- **Overlap and stall:**
  - Stimulus: shifter answers in 1 cycle.
  - Required: BLANK begins exactly the cycle after each on-time ends.
  - Stimulus: shifter answers in 30 cycles.
  - Required: `oe_n_out` stays 1 between the timer end and `shift_done_in`.
- **Wrap and frame_done:**
  - Stimulus: run 12 pairs.
  - Required: `frame_done_out` pulses once, after the latch of (3,2); the next request is (0,0).
- **Restart:**
  - Stimulus: pulse `frame_start_in` during the shift of (2,1).
  - Required: that shift completes and is latched to `addr_out`=2; the next request is (0,0); no `frame_done_out`.
  - Stimulus: assert `rst_in` low during an on-time.
  - Required: `oe_n_out`=1 immediately.
